// File: rtl/booth_seq_mult.sv
// Radix-2 Booth sequential signed multiplier.
// One multiply is in flight at a time, using a start/busy/done handshake.
// An accepted Start loads the operands. Each RUN cycle then does one Booth
// add/subtract followed by an arithmetic right shift of {A,Q,Q(-1)}. After
// data_Width iterations the 2N-bit product is registered and Done pulses
// for one cycle.
// Optional feature macro: BOOTH_ZERO_SKIP_EN. When it is defined, a zero
// operand finishes in a single cycle with Product = 0.
module booth_seq_mult #(
   parameter int data_Width = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      Start,
   input  logic [data_Width-1:0]     Multiplicand,
   input  logic [data_Width-1:0]     Multiplier,
   output logic                      Busy,
   output logic                      Done,
   output logic [2*data_Width-1:0]   Product
);

   localparam int N  = data_Width;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [N:0]         r_a;        // one guard bit so that A - M cannot overflow
   logic [N-1:0]       r_q;
   logic [N-1:0]       r_m;
   logic               r_q_m1;
   logic [CW-1:0]      r_count;
   logic               r_busy;
   logic               r_done;
   logic [2*N-1:0]     r_product;

   logic [N:0]         w_m_ext;
   logic [N:0]         w_sum;

   assign w_m_ext = {r_m[N-1], r_m};

`ifdef BOOTH_ZERO_SKIP_EN
   logic               w_zero_op;
   assign w_zero_op = (Multiplicand == '0) || (Multiplier == '0);
`endif

   // Booth recoding step: add, subtract or pass A depending on {Q[0],Q(-1)}
   always_comb begin
      w_sum = r_a;
      case ({r_q[0], r_q_m1})
         2'b01:   w_sum = r_a + w_m_ext;
         2'b10:   w_sum = r_a - w_m_ext;
         default: w_sum = r_a;
      endcase
   end

   // Control FSM and datapath registers, with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_q       <= '0;
         r_m       <= '0;
         r_q_m1    <= 1'b0;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_busy <= 1'b0;
               r_done <= 1'b0;
               if (Start) begin
                  r_m     <= Multiplicand;
                  r_q     <= Multiplier;
                  r_a     <= '0;
                  r_q_m1  <= 1'b0;
                  r_count <= CW'(N);
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
`ifdef BOOTH_ZERO_SKIP_EN
                  // A zero operand gives a zero product, so skip the iterations
                  if (w_zero_op) begin
                     r_product <= '0;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end
`endif
               end
            end
            S_RUN: begin
               // arithmetic right shift of {sum, Q, Q(-1)}, replicating the sign of A
               r_a     <= {w_sum[N], w_sum[N:1]};
               r_q     <= {w_sum[0], r_q[N-1:1]};
               r_q_m1  <= r_q[0];
               r_count <= r_count - 1'b1;
               if (r_count == CW'(1)) begin
                  // low 2N bits of the post-shift {A,Q}
                  r_product <= {w_sum, r_q[N-1:1]};
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign Busy    = r_busy;
   assign Done    = r_done;
   assign Product = r_product;

endmodule
